zed_bounce_generator: RTL and testbench



---
 rtl/zed_bounce_pkg.sv | 23 ++
 rtl/zed_bounce_channel.sv | 104 ++++++++++
 rtl/zed_bounce_generator.sv | 37 +++
 tb/tb_zed_bounce_generator.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zed_bounce_pkg.sv
// Shared types and constants for the contact-bounce generator.
package zed_bounce_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } bounce_state_t;

  localparam int              LFSR_WIDTH = 16;
  localparam logic [15:0]     LFSR_TAPS  = 16'hB400;

  // Per-channel seed: base seed XOR channel index, never the all-zero lock-up state.
  function automatic logic [LFSR_WIDTH-1:0] channel_seed(
    input logic [LFSR_WIDTH-1:0] seed,
    input logic [LFSR_WIDTH-1:0] index
  );
    logic [LFSR_WIDTH-1:0] s;
    s = seed ^ index;
    if (s == '0) s = 16'h0001;
    return s;
  endfunction

endpackage

// File: rtl/zed_bounce_channel.sv
// One bounce-emulation channel: free-running LFSR, burst FSM, gap and edge counters.
//
// state | meaning
// IDLE  | output settled; a level mismatch launches the first edge of a burst
// GAP   | mid-burst; waiting out the current gap before the next glitch edge
module zed_bounce_channel
  import zed_bounce_pkg::*;
#(
  parameter int                    TOGGLE_WIDTH = 4,
  parameter int                    GAP_WIDTH    = 12,
  parameter logic [LFSR_WIDTH-1:0] SEED         = 16'hACE1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    level,
  input  logic [TOGGLE_WIDTH-1:0] glitch_count,
  input  logic [GAP_WIDTH-1:0]    interval_mask,
  output logic                    bounce,
  output logic                    busy
);

  localparam logic [GAP_WIDTH:0]    GAP_ONE  = 1;
  localparam logic [TOGGLE_WIDTH:0] EDGE_ONE = 1;

  bounce_state_t            state, state_next;
  logic [LFSR_WIDTH-1:0]    lfsr, lfsr_next;
  logic [GAP_WIDTH:0]       gap_cnt, gap_next, gap_load;
  logic [TOGGLE_WIDTH:0]    edges_left, edges_next;
  logic                     bounce_next, busy_next;

  // Gap length drawn from the current LFSR state; 1..2^GAP_WIDTH cycles.
  assign gap_load  = {1'b0, (lfsr[GAP_WIDTH-1:0] & interval_mask)} + GAP_ONE;
  assign lfsr_next = {1'b0, lfsr[LFSR_WIDTH-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);

  // State, counters, LFSR and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= SEED;
      gap_cnt    <= '0;
      edges_left <= '0;
      bounce     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      lfsr       <= lfsr_next;
      gap_cnt    <= gap_next;
      edges_left <= edges_next;
      bounce     <= bounce_next;
      busy       <= busy_next;
    end
  end

  // Next-state logic; disable overrides everything and forces pass-through.
  always_comb begin
    state_next  = state;
    gap_next    = gap_cnt;
    edges_next  = edges_left;
    bounce_next = bounce;
    busy_next   = busy;
    if (!enable) begin
      state_next  = IDLE;
      gap_next    = '0;
      edges_next  = '0;
      bounce_next = level;
      busy_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy_next = 1'b0;
          if (level != bounce) begin
            bounce_next = ~bounce;
            edges_next  = {glitch_count, 1'b0};
            if (glitch_count != '0) begin
              gap_next   = gap_load;
              state_next = GAP;
              busy_next  = 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt <= GAP_ONE) begin
            bounce_next = ~bounce;
            edges_next  = edges_left - EDGE_ONE;
            gap_next    = gap_load;
            if (edges_left <= EDGE_ONE) begin
              state_next = IDLE;
              busy_next  = 1'b0;
              gap_next   = '0;
            end
          end else begin
            gap_next = gap_cnt - GAP_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/zed_bounce_generator.sv
// Contact-bounce emulator for the switch and button channels; one independent channel per input.
module zed_bounce_generator
  import zed_bounce_pkg::*;
#(
  parameter int                    CHANNEL_COUNT = 13,
  parameter int                    TOGGLE_WIDTH  = 4,
  parameter int                    GAP_WIDTH     = 12,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [CHANNEL_COUNT-1:0] i_level,
  input  logic [TOGGLE_WIDTH-1:0]  i_glitch_count,
  input  logic [GAP_WIDTH-1:0]     i_interval_mask,
  output logic [CHANNEL_COUNT-1:0] o_bounce,
  output logic [CHANNEL_COUNT-1:0] o_busy
);

  for (genvar k = 0; k < CHANNEL_COUNT; k++) begin : g_channel
    zed_bounce_channel #(
      .TOGGLE_WIDTH (TOGGLE_WIDTH),
      .GAP_WIDTH    (GAP_WIDTH),
      .SEED         (channel_seed(LFSR_SEED, LFSR_WIDTH'(k)))
    ) u_channel (
      .clock         (i_clock),
      .reset         (i_reset),
      .enable        (i_enable),
      .level         (i_level[k]),
      .glitch_count  (i_glitch_count),
      .interval_mask (i_interval_mask),
      .bounce        (o_bounce[k]),
      .busy          (o_busy[k])
    );
  end

endmodule

// File: tb/tb_zed_bounce_generator.sv
// Self-checking bench for the bounce generator; expectations queued at stimulus time, popped per cycle.
module tb_zed_bounce_generator;

  localparam int CH = 13;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic          i_enable;
  logic [CH-1:0] i_level;
  logic [3:0]    i_glitch_count;
  logic [11:0]   i_interval_mask;
  logic [CH-1:0] o_bounce;
  logic [CH-1:0] o_busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic b;
    logic y;
  } exp_t;

  exp_t          q[$];
  logic          tq[$];
  logic [CH-1:0] lq[$];

  zed_bounce_generator dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_level         (i_level),
    .i_glitch_count  (i_glitch_count),
    .i_interval_mask (i_interval_mask),
    .o_bounce        (o_bounce),
    .o_busy          (o_busy)
  );

  always #5 i_clock = ~i_clock;

  task automatic test_reset();
    i_reset = 1'b1; i_enable = 1'b1; i_level = '0;
    i_glitch_count = 4'd0; i_interval_mask = 12'h000;
    repeat (3) begin
      @(negedge i_clock);
      vectors++;
      if (o_bounce !== '0 || o_busy !== '0) begin
        miscompares++;
        $display("FAIL reset_hold bounce=%h busy=%h want 0/0", o_bounce, o_busy);
      end
    end
    i_reset = 1'b0;
    repeat (100) begin
      @(negedge i_clock);
      vectors++;
      if (o_bounce !== '0 || o_busy !== '0) begin
        miscompares++;
        $display("FAIL reset_quiet bounce=%h busy=%h want 0/0", o_bounce, o_busy);
      end
    end
  endtask

  task automatic test_basic_burst();
    exp_t e;
    i_glitch_count = 4'd2; i_interval_mask = 12'h000;
    i_level[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      e.b = (i <= 5) ? logic'(i % 2) : 1'b1;
      e.y = (i < 5);
      q.push_back(e);
    end
    while (q.size() > 0) begin
      @(negedge i_clock);
      e = q.pop_front();
      vectors++;
      if (o_bounce[0] !== e.b || o_busy[0] !== e.y) begin
        miscompares++;
        $display("FAIL basic_burst bounce0=%b busy0=%b want %b/%b", o_bounce[0], o_busy[0], e.b, e.y);
      end
      vectors++;
      if (o_bounce[CH-1:1] !== '0 || o_busy[CH-1:1] !== '0) begin
        miscompares++;
        $display("FAIL basic_others bounce=%h busy=%h want static 0", o_bounce, o_busy);
      end
    end
  endtask

  task automatic test_single_edge();
    exp_t e;
    i_glitch_count = 4'd0; i_interval_mask = 12'h000;
    i_level[3] = 1'b1;
    @(negedge i_clock);
    vectors++;
    if (o_bounce[3] !== 1'b1 || o_busy[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL single_rise bounce3=%b busy3=%b want 1/0", o_bounce[3], o_busy[3]);
    end
    @(negedge i_clock);
    i_level[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.b = 1'b0; e.y = 1'b0;
      q.push_back(e);
    end
    while (q.size() > 0) begin
      @(negedge i_clock);
      e = q.pop_front();
      vectors++;
      if (o_bounce[3] !== e.b || o_busy[3] !== e.y) begin
        miscompares++;
        $display("FAIL single_fall bounce3=%b busy3=%b want %b/%b", o_bounce[3], o_busy[3], e.b, e.y);
      end
    end
  endtask

  task automatic test_random_gaps();
    logic        prev, target, done;
    int          edges, since, max_gap, distinct;
    logic [16:0] seen;
    seen = '0; max_gap = 0;
    i_glitch_count = 4'd3; i_interval_mask = 12'h00F;
    for (int burst = 0; burst < 50; burst++) begin
      @(negedge i_clock);
      prev   = o_bounce[1];
      target = ~i_level[1];
      tq.push_back(target);
      i_level[1] = target;
      edges = 0; since = 0; done = 1'b0;
      for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
        @(negedge i_clock);
        since++;
        if (o_bounce[1] !== prev) begin
          edges++;
          if (edges > 1) begin
            vectors++;
            if (since < 1 || since > 16) begin
              miscompares++;
              $display("FAIL gap_range burst=%0d gap=%0d want 1..16", burst, since);
            end else begin
              seen[since] = 1'b1;
              if (since > max_gap) max_gap = since;
            end
          end
          since = 0;
          prev  = o_bounce[1];
        end
        if (cyc == 1) begin
          vectors++;
          if (edges != 1 || o_busy[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL burst_start burst=%0d edges=%0d busy=%b want 1/1", burst, edges, o_busy[1]);
          end
        end
        if (o_busy[1] === 1'b0) done = 1'b1;
      end
      vectors++;
      if (!done) begin
        miscompares++;
        $display("FAIL burst_timeout burst=%0d busy still %b want 0 within 400 cycles", burst, o_busy[1]);
      end
      vectors++;
      if (edges != 7) begin
        miscompares++;
        $display("FAIL edge_count burst=%0d edges=%0d want 7", burst, edges);
      end
      target = tq.pop_front();
      vectors++;
      if (o_bounce[1] !== target) begin
        miscompares++;
        $display("FAIL final_level burst=%0d bounce1=%b want %b", burst, o_bounce[1], target);
      end
    end
    distinct = 0;
    for (int g = 1; g <= 16; g++) if (seen[g]) distinct++;
    vectors++;
    if (distinct < 8 || max_gap < 12) begin
      miscompares++;
      $display("FAIL gap_spread distinct=%0d max=%0d want >=8 distinct and max >=12", distinct, max_gap);
    end
  endtask

  task automatic test_mid_burst_level();
    exp_t e;
    int   j;
    i_glitch_count = 4'd4; i_interval_mask = 12'h000;
    @(negedge i_clock);
    i_level[2] = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      if (i <= 9) begin
        e.b = logic'(i % 2); e.y = (i < 9);
      end else if (i <= 18) begin
        j = i - 9;
        e.b = ~logic'(j % 2); e.y = (j < 9);
      end else begin
        e.b = 1'b0; e.y = 1'b0;
      end
      q.push_back(e);
    end
    for (int i = 1; q.size() > 0; i++) begin
      @(negedge i_clock);
      e = q.pop_front();
      vectors++;
      if (o_bounce[2] !== e.b || o_busy[2] !== e.y) begin
        miscompares++;
        $display("FAIL mid_burst cyc=%0d bounce2=%b busy2=%b want %b/%b", i, o_bounce[2], o_busy[2], e.b, e.y);
      end
      if (i == 3) i_level[2] = 1'b0;
    end
  endtask

  task automatic test_enable_drop();
    logic [CH-1:0] lv, want;
    i_glitch_count = 4'd4; i_interval_mask = 12'h000;
    @(negedge i_clock);
    i_level[4] = 1'b1;
    @(negedge i_clock);
    vectors++;
    if (o_bounce[4] !== 1'b1 || o_busy[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_start bounce4=%b busy4=%b want 1/1", o_bounce[4], o_busy[4]);
    end
    @(negedge i_clock);
    vectors++;
    if (o_bounce[4] !== 1'b0 || o_busy[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_glitch bounce4=%b busy4=%b want 0/1", o_bounce[4], o_busy[4]);
    end
    i_enable = 1'b0;
    lq.push_back(i_level);
    for (int s = 0; s < 12; s++) begin
      @(negedge i_clock);
      want = lq.pop_front();
      vectors++;
      if (o_bounce !== want || o_busy !== '0) begin
        miscompares++;
        $display("FAIL pass_through step=%0d bounce=%h busy=%h want %h/0", s, o_bounce, o_busy, want);
      end
      if (s % 2 == 0) begin
        lv = CH'($urandom());
        i_level = lv;
      end
      lq.push_back(i_level);
    end
    lq.delete();
    @(negedge i_clock);
    want = i_level;
    i_enable = 1'b1;
    repeat (5) begin
      @(negedge i_clock);
      vectors++;
      if (o_bounce !== want || o_busy !== '0) begin
        miscompares++;
        $display("FAIL reenable_quiet bounce=%h busy=%h want %h/0", o_bounce, o_busy, want);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    i_enable = 1'b0; i_level = '0;
    repeat (2) @(negedge i_clock);
    i_enable = 1'b1; i_glitch_count = 4'd4; i_interval_mask = 12'h00F;
    i_level[5] = 1'b1;
    repeat (3) @(negedge i_clock);
    vectors++;
    if (o_busy[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_busy busy5=%b want 1", o_busy[5]);
    end
    #2 i_reset = 1'b1;
    #1;
    vectors++;
    if (o_bounce !== '0 || o_busy !== '0) begin
      miscompares++;
      $display("FAIL rst_async bounce=%h busy=%h want 0/0", o_bounce, o_busy);
    end
    i_level = '0;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    repeat (20) begin
      @(negedge i_clock);
      vectors++;
      if (o_bounce !== '0 || o_busy !== '0) begin
        miscompares++;
        $display("FAIL rst_release bounce=%h busy=%h want 0/0", o_bounce, o_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_single_edge();
    test_random_gaps();
    test_mid_burst_level();
    test_enable_drop();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
